// File: rtl/fpmult_iter.sv
// fpmult_iter: iterative signed fixed-point multiplier with optional
// multiply-accumulate. Start/ready/valid slave, one operation in flight.
//
// Inputs are P_IN.Q_IN two's complement. The output is P_OUT.Q_OUT, rounded
// with one of four modes and saturated. The exact product is built by a
// magnitude shift-add that retires R multiplier bits per cycle.
//
// Optional feature macro: FPMULT_ITER_ACC_EN. When it is defined, a
// full-precision accumulator is built and acc_in selects add or replace.
// When it is undefined, acc_in is ignored.
//
// Ports:
//   clk_in     rising-edge clock
//   rst_in     synchronous active-high reset; aborts any operation
//   x_in       multiplicand, P_IN+Q_IN bits signed
//   y_in       multiplier, P_IN+Q_IN bits signed
//   round_in   00 floor, 01 toward zero, 10 nearest/ties up, 11 nearest/ties even
//   acc_in     1: add product to accumulator, 0: product replaces it
//   start_in   request, taken when start_in & ready_out
//   p_out      rounded, saturated result, P_OUT+Q_OUT bits
//   oor_out    [0] +sat, [1] -sat, [2] underflow, [3] inexact
//   valid_out  one-cycle strobe, p_out/oor_out just updated
//   ready_out  idle or finishing, a start is accepted
//
// state | meaning
// IDLE  | waiting for start
// MUL   | shift-add, N_ITER cycles
// ROUND | sum, round, saturate; registers p_out/oor_out and accumulator
// DONE  | valid strobe; a new start goes straight to MUL

module fpmult_iter #(
    parameter int P_IN  = 8,
    parameter int Q_IN  = 8,
    parameter int P_OUT = 8,
    parameter int Q_OUT = 8,
    parameter int R     = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [P_IN+Q_IN-1:0]   x_in,
    input  logic [P_IN+Q_IN-1:0]   y_in,
    input  logic [1:0]             round_in,
    input  logic                   acc_in,
    input  logic                   start_in,
    output logic [P_OUT+Q_OUT-1:0] p_out,
    output logic [3:0]             oor_out,
    output logic                   valid_out,
    output logic                   ready_out
);

    localparam int W_IN   = P_IN + Q_IN;
    localparam int W_OUT  = P_OUT + Q_OUT;
    localparam int N_ITER = (W_IN + R - 1) / R;
    localparam int W_Y    = N_ITER * R;
    localparam int W_P    = 2 * W_IN;
    localparam int W_ACC  = 2 * W_IN + 4;
    localparam int D      = 2 * Q_IN - Q_OUT;
    // Sum is padded with two zero LSBs so the half/rest masks exist even when D=0.
    localparam int DS     = D + 2;
    localparam int W_S    = W_ACC + 3;
    localparam int W_C    = (W_S > W_OUT + 1) ? W_S : W_OUT + 1;
    localparam int W_CNT  = $clog2(N_ITER + 1);

    localparam logic [W_S-1:0] HALF_MASK = W_S'(1) << (DS - 1);
    localparam logic [W_S-1:0] LOW_MASK  = HALF_MASK - W_S'(1);
    localparam logic [W_S-1:0] FRAC_MASK = HALF_MASK | LOW_MASK;
    localparam logic signed [W_C-1:0] MAX_C = (W_C'(1) << (W_OUT - 1)) - W_C'(1);
    localparam logic signed [W_C-1:0] MIN_C = -(W_C'(1) << (W_OUT - 1));

    generate
        if (Q_OUT > 2 * Q_IN) begin : g_bad_qout
            $error("fpmult_iter: Q_OUT must not exceed 2*Q_IN");
        end
        if (R < 1 || R > W_IN) begin : g_bad_r
            $error("fpmult_iter: R must be in 1..P_IN+Q_IN");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [W_CNT-1:0]   cnt;
    logic [W_P-1:0]     mcand;
    logic [W_Y-1:0]     mplier;
    logic [W_P-1:0]     prod;
    logic               neg;
    logic [1:0]         rnd_mode;

    logic [W_IN-1:0]    x_mag, y_mag;
    logic [W_P-1:0]     digit;
    logic [W_ACC-1:0]   prod_s, s_sum;
    logic signed [W_S-1:0] s_ext, q, r;
    logic signed [W_C-1:0] r_c;
    logic               inexact, half, rest, inc;
    logic               sat_pos, sat_neg, underflow;
    logic [W_OUT-1:0]   p_nxt;

    // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits, so negation is exact.
    assign x_mag = x_in[W_IN-1] ? (-x_in) : x_in;
    assign y_mag = y_in[W_IN-1] ? (-y_in) : y_in;
    assign digit = W_P'(mplier[R-1:0]);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready_out = 1'b0;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (start_in) begin
                    accept    = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL:   if (cnt == '0) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE: begin
                ready_out = 1'b1;
                valid_out = 1'b1;
                if (start_in) begin
                    accept    = 1'b1;
                    state_nxt = MUL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            neg      <= 1'b0;
            rnd_mode <= '0;
            p_out    <= '0;
            oor_out  <= '0;
        end else if (accept) begin
            cnt      <= W_CNT'(N_ITER - 1);
            mcand    <= W_P'(x_mag);
            mplier   <= W_Y'(y_mag);
            prod     <= '0;
            neg      <= x_in[W_IN-1] ^ y_in[W_IN-1];
            rnd_mode <= round_in;
        end else if (state == MUL) begin
            prod   <= prod + mcand * digit;
            mcand  <= mcand << R;
            mplier <= mplier >> R;
            if (cnt != '0) cnt <= cnt - W_CNT'(1);
        end else if (state == ROUND) begin
            p_out   <= p_nxt;
            oor_out <= {inexact, underflow, sat_neg, sat_pos};
        end
    end

    assign prod_s = neg ? (-W_ACC'(prod)) : W_ACC'(prod);

`ifdef FPMULT_ITER_ACC_EN
    logic             acc_sel;
    logic [W_ACC-1:0] acc_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_sel <= 1'b0;
            acc_q   <= '0;
        end else begin
            if (accept)         acc_sel <= acc_in;
            if (state == ROUND) acc_q   <= s_sum;
        end
    end

    assign s_sum = prod_s + (acc_sel ? acc_q : '0);
`else
    logic unused_acc_in;
    assign unused_acc_in = acc_in;
    assign s_sum = prod_s;
`endif

    assign s_ext   = {s_sum[W_ACC-1], s_sum, 2'b00};
    assign q       = s_ext >>> DS;
    assign inexact = |(s_ext & FRAC_MASK);
    assign half    = |(s_ext & HALF_MASK);
    assign rest    = |(s_ext & LOW_MASK);

    always_comb begin
        inc = 1'b0;
        case (rnd_mode)
            2'b00:   inc = 1'b0;
            2'b01:   inc = s_ext[W_S-1] & inexact;
            2'b10:   inc = half;
            2'b11:   inc = half & (rest | q[0]);
            default: inc = 1'b0;
        endcase
    end

    // q carries DS spare sign bits, so the increment cannot overflow.
    assign r   = q + W_S'(inc);
    assign r_c = W_C'(r);

    assign sat_pos   = (r_c > MAX_C);
    assign sat_neg   = (r_c < MIN_C);
    assign p_nxt     = sat_pos ? MAX_C[W_OUT-1:0] :
                       sat_neg ? MIN_C[W_OUT-1:0] : r_c[W_OUT-1:0];
    assign underflow = (s_sum != '0) && (p_nxt == '0);

endmodule

// File: tb/tb_fpmult_iter.sv
module tb_fpmult_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x, y;
    logic [1:0]  rnd;
    logic        acc;
    logic        start1, start4;
    logic [15:0] p1, p4;
    logic [3:0]  oor1, oor4;
    logic        v1, v4, rdy1, rdy4;

    int n_checks = 0;
    int n_pass   = 0;
    logic [19:0] exp_q[$];

`ifdef FPMULT_ITER_ACC_EN
    localparam bit ACC_BUILT = 1'b1;
`else
    localparam bit ACC_BUILT = 1'b0;
`endif

    always #5 clk = ~clk;

    fpmult_iter #(.R(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .round_in(rnd),
        .acc_in(acc), .start_in(start1), .p_out(p1), .oor_out(oor1),
        .valid_out(v1), .ready_out(rdy1)
    );

    fpmult_iter #(.R(4)) u_dut4 (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .round_in(rnd),
        .acc_in(acc), .start_in(start4), .p_out(p4), .oor_out(oor4),
        .valid_out(v4), .ready_out(rdy4)
    );

    // Reference: exact integer product in units of 2^-16, rounded to 2^-8.
    function automatic logic [19:0] model(input logic [15:0] xv, input logic [15:0] yv,
                                          input logic [1:0] rv, input longint acc_v);
        longint s, qq, rem, rr;
        logic [15:0] pv;
        logic [3:0]  o;
        s   = longint'($signed(xv)) * longint'($signed(yv)) + acc_v;
        qq  = s >>> 8;
        rem = s - qq * 256;
        rr  = qq;
        case (rv)
            2'd1: if (s < 0 && rem != 0) rr = qq + 1;
            2'd2: if (rem >= 128) rr = qq + 1;
            2'd3: if (rem > 128 || (rem == 128 && (qq % 2) != 0)) rr = qq + 1;
            default: ;
        endcase
        o = 4'b0000;
        if (rr > 32767) begin
            pv = 16'h7FFF; o[0] = 1'b1;
        end else if (rr < -32768) begin
            pv = 16'h8000; o[1] = 1'b1;
        end else begin
            pv = rr[15:0];
        end
        o[3] = (rem != 0);
        o[2] = (s != 0) && (pv == 16'h0000);
        return {o, pv};
    endfunction

    // Called at a negedge with the target idle; returns at the negedge after the accept edge.
    task automatic issue(input bit sel4, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [1:0] rv, input logic av);
        x = xv; y = yv; rnd = rv; acc = av;
        if (sel4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        x = $urandom; y = $urandom; rnd = 2'($urandom); acc = 1'($urandom);
    endtask

    // lat = number of negedges from the accept edge to the valid strobe, -1 on timeout.
    task automatic wait_valid(input bit sel4, output int lat, output bit rdy_low);
        int c;
        c = 1; lat = -1; rdy_low = 1'b1;
        while (c <= 40) begin
            if (sel4 ? v4 : v1) begin
                lat = c;
                break;
            end
            if (sel4 ? rdy4 : rdy1) rdy_low = 1'b0;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs, expv;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        x = '0; y = '0; rnd = '0; acc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs  = {p1, oor1, v1, rdy1, 2'b00, p4[7:0]};
        expv = {16'h0000, 4'h0, 1'b0, 1'b1, 2'b00, 8'h00};
        n_checks++;
        if (obs !== expv) $display("FAIL reset_dut1 got=%h exp=%h", obs, expv);
        else n_pass++;
        n_checks++;
        if ({p4, oor4, v4, rdy4} !== {16'h0000, 4'h0, 1'b0, 1'b1})
            $display("FAIL reset_dut4 got=%h exp=%h", {p4, oor4, v4, rdy4}, 22'h1);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat; bit rl; logic [19:0] e;
        exp_q.push_back({4'b0000, 16'hFCA0});
        issue(1'b0, 16'h0180, 16'hFDC0, 2'b00, 1'b0);
        wait_valid(1'b0, lat, rl);
        n_checks++;
        if (lat !== 18) $display("FAIL basic_latency got=%0d exp=18", lat);
        else n_pass++;
        n_checks++;
        if (rl !== 1'b1 || rdy1 !== 1'b1) $display("FAIL basic_ready got_low=%0b got_rdy=%0b exp=1,1", rl, rdy1);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({oor1, p1} !== e) $display("FAIL basic_result got=%h exp=%h", {oor1, p1}, e);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({v1, oor1, p1} !== {1'b0, e}) $display("FAIL basic_hold got=%h exp=%h", {v1, oor1, p1}, {1'b0, e});
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] tx[3] = '{16'h6400, 16'h8000, 16'h8000};
        logic [15:0] ty[3] = '{16'h0200, 16'h0200, 16'h8000};
        logic [19:0] te[3] = '{{4'b0001, 16'h7FFF}, {4'b0010, 16'h8000}, {4'b0001, 16'h7FFF}};
        int lat; bit rl; logic [19:0] e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(te[i]);
            issue(1'b0, tx[i], ty[i], 2'b00, 1'b0);
            wait_valid(1'b0, lat, rl);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 18 || {oor1, p1} !== e)
                $display("FAIL sat_%0d got=%h lat=%0d exp=%h lat=18", i, {oor1, p1}, lat, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] tx[8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic [19:0] te[8] = '{{4'b1100, 16'h0000}, {4'b1100, 16'h0000},
                               {4'b1000, 16'h0001}, {4'b1100, 16'h0000},
                               {4'b1000, 16'hFFFF}, {4'b1100, 16'h0000},
                               {4'b1100, 16'h0000}, {4'b1100, 16'h0000}};
        int lat; bit rl; logic [19:0] e;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(te[i]);
            issue(1'b0, tx[i], 16'h0080, 2'(i % 4), 1'b0);
            wait_valid(1'b0, lat, rl);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 18 || {oor1, p1} !== e)
                $display("FAIL round_%0d got=%h lat=%0d exp=%h lat=18", i, {oor1, p1}, lat, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat; bit rl; logic [19:0] e;
        logic [15:0] xv, yv; logic [1:0] rv;
        for (int i = 0; i < 8; i++) begin
            xv = 16'($urandom); yv = 16'($urandom); rv = 2'($urandom);
            if (i < 4) yv = {{6{yv[15]}}, yv[9:0]};
            exp_q.push_back(model(xv, yv, rv, 0));
            issue(1'b0, xv, yv, rv, 1'b0);
            wait_valid(1'b0, lat, rl);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 18 || {oor1, p1} !== e)
                $display("FAIL rand_%0d x=%h y=%h r=%0d got=%h exp=%h lat=%0d", i, xv, yv, rv, {oor1, p1}, e, lat);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit rl; logic [19:0] e;
        exp_q.push_back({4'b0000, 16'h0100});
        issue(1'b1, 16'h0100, 16'h0100, 2'b00, 1'b0);
        wait_valid(1'b1, lat, rl);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 6 || rl !== 1'b1 || {oor4, p4} !== e)
            $display("FAIL b2b_first got=%h lat=%0d rl=%0b exp=%h lat=6", {oor4, p4}, lat, rl, e);
        else n_pass++;
        // Issue straight from the valid cycle.
        exp_q.push_back(ACC_BUILT ? {4'b0000, 16'h0200} : {4'b0000, 16'h0100});
        issue(1'b1, 16'h0100, 16'h0100, 2'b00, 1'b1);
        wait_valid(1'b1, lat, rl);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 6) $display("FAIL b2b_spacing got=%0d exp=6", lat);
        else n_pass++;
        n_checks++;
        if ({oor4, p4} !== e) $display("FAIL b2b_second got=%h exp=%h", {oor4, p4}, e);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; bit rl; int strobes; logic [19:0] e;
        exp_q.push_back({4'b0000, 16'h0200});
        issue(1'b0, 16'h0200, 16'h0100, 2'b00, 1'b0);
        wait_valid(1'b0, lat, rl);
        e = exp_q.pop_front();
        n_checks++;
        if ({oor1, p1} !== e) $display("FAIL abort_pre got=%h exp=%h", {oor1, p1}, e);
        else n_pass++;
        @(negedge clk);
        issue(1'b0, 16'h0300, 16'h0200, 2'b00, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({p1, oor1, v1, rdy1} !== {16'h0000, 4'h0, 1'b0, 1'b1})
            $display("FAIL abort_state got=%h exp=%h", {p1, oor1, v1, rdy1}, 22'h1);
        else n_pass++;
        strobes = 0;
        repeat (25) begin
            @(negedge clk);
            if (v1) strobes++;
        end
        n_checks++;
        if (strobes !== 0) $display("FAIL abort_no_strobe got=%0d exp=0", strobes);
        else n_pass++;
        exp_q.push_back({4'b0000, 16'h0100});
        issue(1'b0, 16'h0100, 16'h0100, 2'b00, 1'b1);
        wait_valid(1'b0, lat, rl);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 18 || {oor1, p1} !== e)
            $display("FAIL abort_acc_cleared got=%h lat=%0d exp=%h lat=18", {oor1, p1}, lat, e);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
